// File: rtl/mc8051_mc_sequencer_pkg.sv
// Shared types and microcode contents for the mc8051 microcode sequencer.
// The built-in ROM image is generated by mc_rom_entry() rather than loaded from a file.
package mc8051_mc_sequencer_pkg;

  localparam int OP_W_DEF        = 8;
  localparam int STAGE_W_DEF     = 2;
  localparam int MCODE_WIDTH_DEF = 64;
  localparam int PAYLOAD_W       = 62;

  // END sits at MCODE_WIDTH-1 and DEF at MCODE_WIDTH-2.
  localparam int MC_END_OFS = 1;
  localparam int MC_DEF_OFS = 2;

  localparam int unsigned ILLEGAL_OP = 32'hA5;
  localparam int unsigned MC_TAG     = 32'h5A;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic                 end_f;
    logic                 def_f;
    logic [PAYLOAD_W-1:0] payload;
  } mc_entry_t;

  // Image: opcode op runs (op%4)+1 stages; when a 4-stage op has bit 2 set,
  // its last stage carries no END, so the stage limit is what terminates it.
  // 0xA5 is undefined: a DEF=0 NOP with END=1 at stage 0.
  function automatic mc_entry_t mc_rom_entry(input int unsigned stage,
                                             input int unsigned op,
                                             input int unsigned max_stages);
    mc_entry_t   e;
    int unsigned len;
    logic [PAYLOAD_W-1:0] pl;
    e   = '0;
    len = (op % 4) + 1;
    if (len > max_stages) len = max_stages;
    pl = (PAYLOAD_W'(MC_TAG) << 24) | (PAYLOAD_W'(stage) << 16) | PAYLOAD_W'(op);
    if (op == ILLEGAL_OP) begin
      if (stage == 0) begin
        e.end_f   = 1'b1;
        e.payload = pl;
      end
    end else if (stage < len) begin
      e.def_f   = 1'b1;
      e.end_f   = (stage == len - 1) && !((len == 4) && (((op >> 2) & 1) == 1));
      e.payload = pl;
    end
    return e;
  endfunction

endpackage

// File: rtl/mc8051_mc_rom.sv
// Microcode ROM addressed by {stage, opcode}; read is registered into o_mc_b.
// A trap request replaces the read word with the END-only trap microword.
module mc8051_mc_rom
  import mc8051_mc_sequencer_pkg::*;
#(
  parameter int OP_W        = OP_W_DEF,
  parameter int STAGE_W     = STAGE_W_DEF,
  parameter int MCODE_WIDTH = MCODE_WIDTH_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [STAGE_W-1:0]     i_rd_stage,
  input  logic [OP_W-1:0]        i_rd_op,
  input  logic                   i_load,
  input  logic                   i_clear,
  input  logic                   i_trap,
  output logic                   o_rd_def,
  output logic [MCODE_WIDTH-1:0] o_mc_b
);

  localparam logic [MCODE_WIDTH-1:0] TRAP_WORD = {1'b1, {(MCODE_WIDTH-1){1'b0}}};

  mc_entry_t              entry;
  logic [MCODE_WIDTH-1:0] rom_word;
  logic [MCODE_WIDTH-1:0] mc_q;

  always_comb begin
    entry    = mc_rom_entry(32'(i_rd_stage), 32'(i_rd_op), 32'(2**STAGE_W));
    rom_word = {entry.end_f, entry.def_f, (MCODE_WIDTH-2)'(entry.payload)};
    o_rd_def = entry.def_f;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mc_q <= '0;
    end else if (i_clear) begin
      mc_q <= '0;
    end else if (i_load) begin
      mc_q <= i_trap ? TRAP_WORD : rom_word;
    end
  end

  assign o_mc_b = mc_q;

endmodule

// File: rtl/mc8051_mc_sequencer.sv
// mc8051 microcode sequencer: accepts an opcode, then steps stages until END or the stage limit.
// Optional feature: define MC_ILLEGAL_TRAP_EN to trap opcodes whose stage-0 entry has DEF=0.
module mc8051_mc_sequencer
  import mc8051_mc_sequencer_pkg::*;
#(
  parameter int OP_W        = OP_W_DEF,
  parameter int STAGE_W     = STAGE_W_DEF,
  parameter int MCODE_WIDTH = MCODE_WIDTH_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [OP_W-1:0]        i_op,
  input  logic                   i_op_valid,
  output logic                   o_op_ready,
  input  logic                   i_stall,
  input  logic                   i_flush,
  output logic [MCODE_WIDTH-1:0] o_mc_b,
  output logic                   o_mc_valid,
  output logic [STAGE_W-1:0]     o_ci_stage,
  output logic                   o_last,
  output logic                   o_illegal,
  output seq_state_e             o_dbg_state
);

`ifdef MC_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  localparam logic [STAGE_W-1:0] STAGE_MAX = '1;

  seq_state_e         state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic               illegal_q, illegal_d;

  logic               run, accept;
  logic               start_new, advance, go_idle;
  logic               rom_trap, rd_def;
  logic [STAGE_W-1:0] rd_stage;
  logic [OP_W-1:0]    rd_op;

  // Handshake: an opcode transfers on a cycle where i_op_valid and o_op_ready are both high;
  // o_op_ready never depends on i_op_valid or i_op, and flush always withholds it.
  assign run        = (state_q == ST_RUN);
  assign o_last     = run & (o_mc_b[MCODE_WIDTH-MC_END_OFS] | (stage_q == STAGE_MAX));
  assign o_op_ready = ~i_flush & (~run | (o_last & ~i_stall));
  assign accept     = i_op_valid & o_op_ready;

  always_comb begin
    start_new = 1'b0;
    advance   = 1'b0;
    go_idle   = 1'b0;
    if (i_flush) begin
      go_idle = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: start_new = accept;
        ST_RUN: begin
          if (!i_stall) begin
            if (!o_last)     advance   = 1'b1;
            else if (accept) start_new = 1'b1;
            else             go_idle   = 1'b1;
          end
        end
        default: go_idle = 1'b1;
      endcase
    end
  end

  // Address for the ROM read that lands in o_mc_b on the next edge.
  always_comb begin
    rd_op    = start_new ? i_op : op_q;
    rd_stage = start_new ? '0 : (advance ? stage_q + STAGE_W'(1) : stage_q);
  end

  assign rom_trap = TRAP_EN & start_new & ~rd_def;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    stage_d   = stage_q;
    illegal_d = illegal_q;
    if (go_idle) begin
      state_d   = ST_IDLE;
      stage_d   = '0;
      illegal_d = 1'b0;
    end else if (start_new) begin
      state_d   = ST_RUN;
      op_d      = i_op;
      stage_d   = '0;
      illegal_d = rom_trap;
    end else if (advance) begin
      stage_d   = stage_q + STAGE_W'(1);
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      stage_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      stage_q   <= stage_d;
      illegal_q <= illegal_d;
    end
  end

  mc8051_mc_rom #(
    .OP_W        (OP_W),
    .STAGE_W     (STAGE_W),
    .MCODE_WIDTH (MCODE_WIDTH)
  ) u_rom (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rd_stage (rd_stage),
    .i_rd_op    (rd_op),
    .i_load     (start_new | advance),
    .i_clear    (go_idle),
    .i_trap     (rom_trap),
    .o_rd_def   (rd_def),
    .o_mc_b     (o_mc_b)
  );

  assign o_mc_valid  = run;
  assign o_ci_stage  = stage_q;
  assign o_illegal   = illegal_q;
  assign o_dbg_state = state_q;

endmodule
